// File: rtl/fp_wb_arbiter_if.sv
// rtl/fp_wb_arbiter_if.sv - ALU/load writeback requests and FP register file write port
interface fp_wb_arbiter_if;
  logic        AluReq;
  logic [4:0]  AluFmt;
  logic [4:0]  AluReg;
  logic [63:0] AluData;
  logic        AluGnt;
  logic        LdReq;
  logic [4:0]  LdFmt;
  logic [4:0]  LdReg;
  logic [63:0] LdData;
  logic        LdGnt;
  logic        FPRegWrite;
  logic [4:0]  FPWriteRegister;
  logic [31:0] FPWriteData;
  logic        Busy;

  modport slave (
    input  AluReq, AluFmt, AluReg, AluData,
    input  LdReq, LdFmt, LdReg, LdData,
    output AluGnt, LdGnt,
    output FPRegWrite, FPWriteRegister, FPWriteData, Busy
  );

  modport master (
    output AluReq, AluFmt, AluReg, AluData,
    output LdReq, LdFmt, LdReg, LdData,
    input  AluGnt, LdGnt,
    input  FPRegWrite, FPWriteRegister, FPWriteData, Busy
  );
endinterface

// File: rtl/fp_wb_arbiter.sv
// rtl/fp_wb_arbiter.sv - round-robin arbiter serialising FP ALU and load writebacks
// into 32-bit register file writes; doubles take two cycles (reg, reg+1).
module fp_wb_arbiter #(
  parameter logic [4:0] FMT_S = 5'h10,
  parameter logic [4:0] FMT_D = 5'h11
) (
  input logic           clk,
  input logic           rst_n,
  fp_wb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WR_S, WR_LO, WR_HI} state_t;

  state_t      state, state_nxt;
  logic        ptr_ld, ptr_ld_nxt;
  logic [4:0]  cap_reg;
  logic [63:0] cap_data;

  logic        accept;
  logic        alu_gnt, ld_gnt, any_gnt;
  logic [4:0]  win_fmt, win_reg;
  logic [63:0] win_data;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;

  // Acceptance is allowed whenever the word being written this cycle is the
  // last one of its transaction, so back-to-back writebacks have no bubble.
  always_comb begin
    accept     = rst_n && (state != WR_LO);
    alu_gnt    = accept && bus.AluReq && (!bus.LdReq || !ptr_ld);
    ld_gnt     = accept && bus.LdReq && !alu_gnt;
    any_gnt    = alu_gnt || ld_gnt;
    win_fmt    = ld_gnt ? bus.LdFmt  : bus.AluFmt;
    win_reg    = ld_gnt ? bus.LdReg  : bus.AluReg;
    win_data   = ld_gnt ? bus.LdData : bus.AluData;
    ptr_ld_nxt = ptr_ld;
    if (alu_gnt) begin
      ptr_ld_nxt = 1'b1;
    end else if (ld_gnt) begin
      ptr_ld_nxt = 1'b0;
    end
    state_nxt = IDLE;
    if (state == WR_LO) begin
      state_nxt = WR_HI;
    end else if (any_gnt) begin
      if (win_fmt == FMT_S) begin
        state_nxt = WR_S;
      end else if (win_fmt == FMT_D) begin
        state_nxt = WR_LO;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr_ld   <= 1'b0;
      cap_reg  <= 5'd0;
      cap_data <= 64'd0;
    end else begin
      state  <= state_nxt;
      ptr_ld <= ptr_ld_nxt;
      if (any_gnt) begin
        cap_reg  <= win_reg;
        cap_data <= win_data;
      end
    end
  end

  // Write port decodes only registered state, never the request inputs.
  always_comb begin
    wr_reg  = 5'd0;
    wr_data = 32'd0;
    case (state)
      WR_S, WR_LO: begin
        wr_reg  = cap_reg;
        wr_data = cap_data[31:0];
      end
      WR_HI: begin
        wr_reg  = cap_reg + 5'd1;
        wr_data = cap_data[63:32];
      end
      default: begin
        wr_reg  = 5'd0;
        wr_data = 32'd0;
      end
    endcase
  end

  assign bus.AluGnt          = alu_gnt;
  assign bus.LdGnt           = ld_gnt;
  assign bus.FPRegWrite      = (state != IDLE) && (wr_reg != 5'd0);
  assign bus.FPWriteRegister = wr_reg;
  assign bus.FPWriteData     = wr_data;
  assign bus.Busy            = (state != IDLE);

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb/tb_fp_wb_arbiter.sv - vector table, corner sequences and random run against a
// queue-based model of the FP writeback arbiter.
module tb_fp_wb_arbiter;

  localparam logic [4:0] FMT_S = 5'h10;
  localparam logic [4:0] FMT_D = 5'h11;

  logic clk;
  logic rst_n;
  fp_wb_arbiter_if bus ();

  fp_wb_arbiter #(.FMT_S(FMT_S), .FMT_D(FMT_D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic a_req, input logic [4:0] a_fmt, input logic [4:0] a_reg,
                       input logic [63:0] a_data, input logic l_req, input logic [4:0] l_fmt,
                       input logic [4:0] l_reg, input logic [63:0] l_data);
    bus.AluReq  = a_req;
    bus.AluFmt  = a_fmt;
    bus.AluReg  = a_reg;
    bus.AluData = a_data;
    bus.LdReq   = l_req;
    bus.LdFmt   = l_fmt;
    bus.LdReg   = l_reg;
    bus.LdData  = l_data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] r,
                          input logic [31:0] d, input logic b);
    chk({tag, ".we"},   {63'd0, bus.FPRegWrite}, {63'd0, we});
    chk({tag, ".reg"},  {59'd0, bus.FPWriteRegister}, {59'd0, r});
    chk({tag, ".data"}, {32'd0, bus.FPWriteData}, {32'd0, d});
    chk({tag, ".busy"}, {63'd0, bus.Busy}, {63'd0, b});
  endtask

  typedef struct {
    logic        a_req;
    logic [4:0]  a_fmt;
    logic [4:0]  a_reg;
    logic [63:0] a_data;
    logic        l_req;
    logic [4:0]  l_fmt;
    logic [4:0]  l_reg;
    logic [63:0] l_data;
    logic        e_ag;
    logic        e_lg;
    logic        e_we1;
    logic [4:0]  e_reg1;
    logic [31:0] e_d1;
    logic        e_b1;
    logic        e_we2;
    logic [4:0]  e_reg2;
    logic [31:0] e_d2;
    logic        e_b2;
  } vec_t;

  vec_t vecs[6];

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  // Random-run requester state and model state.
  logic        a_req, l_req;
  logic [4:0]  a_fmt, a_reg, l_fmt, l_reg;
  logic [63:0] a_data, l_data;
  logic        m_ptr_ld;
  wr_t         m_q[$];

  function automatic logic [4:0] rand_fmt();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k < 4) return FMT_S;
    if (k < 8) return FMT_D;
    return 5'($urandom_range(0, 31) | 5'h04) ^ 5'h10;
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 64'd0);

    vecs[0] = '{1'b1, 5'h10, 5'd5, 64'h0123_4567_DEAD_BEEF, 1'b0, 5'h00, 5'd0, 64'h0,
                1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 5'h00, 5'd0, 64'h0, 1'b1, 5'h11, 5'd31, 64'h1111_2222_3333_4444,
                1'b0, 1'b1, 1'b1, 5'd31, 32'h3333_4444, 1'b1, 1'b0, 5'd0, 32'h1111_2222, 1'b1};
    vecs[2] = '{1'b1, 5'h14, 5'd7, 64'hFFFF_0000_FFFF_0000, 1'b0, 5'h00, 5'd0, 64'h0,
                1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 5'h00, 5'd0, 64'h0, 1'b1, 5'h10, 5'd0, 64'hAAAA_5555_0123_4567,
                1'b0, 1'b1, 1'b0, 5'd0, 32'h0123_4567, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 5'h11, 5'd4, 64'h89AB_CDEF_FEDC_BA98, 1'b0, 5'h00, 5'd0, 64'h0,
                1'b1, 1'b0, 1'b1, 5'd4, 32'hFEDC_BA98, 1'b1, 1'b1, 5'd5, 32'h89AB_CDEF, 1'b1};
    vecs[5] = '{1'b0, 5'h00, 5'd0, 64'h0, 1'b1, 5'h00, 5'd3, 64'h1234_5678_9ABC_DEF0,
                1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0};

    #2;
    chk("reset.alu_gnt", {63'd0, bus.AluGnt}, 64'd0);
    chk("reset.ld_gnt",  {63'd0, bus.LdGnt},  64'd0);
    chk_port("reset", 1'b0, 5'd0, 32'd0, 1'b0);
    do_reset();

    // Table: one isolated transaction per entry, grant then two write cycles.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].a_req, vecs[i].a_fmt, vecs[i].a_reg, vecs[i].a_data,
            vecs[i].l_req, vecs[i].l_fmt, vecs[i].l_reg, vecs[i].l_data);
      @(negedge clk);
      chk($sformatf("vec%0d.alu_gnt", i), {63'd0, bus.AluGnt}, {63'd0, vecs[i].e_ag});
      chk($sformatf("vec%0d.ld_gnt", i),  {63'd0, bus.LdGnt},  {63'd0, vecs[i].e_lg});
      @(posedge clk);
      #1;
      drive(1'b0, 5'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 64'd0);
      @(negedge clk);
      chk_port($sformatf("vec%0d.w1", i), vecs[i].e_we1, vecs[i].e_reg1, vecs[i].e_d1, vecs[i].e_b1);
      @(negedge clk);
      chk_port($sformatf("vec%0d.w2", i), vecs[i].e_we2, vecs[i].e_reg2, vecs[i].e_d2, vecs[i].e_b2);
      @(posedge clk);
      #1;
    end

    // Both requesting singles continuously: strict alternation from ALU, no bubble.
    do_reset();
    begin
      logic [4:0] last_reg;
      logic [4:0] nr;
      last_reg = 5'd0;
      nr = 5'd3;
      drive(1'b1, FMT_S, 5'd1, 64'h0000_0000_A000_0001, 1'b1, FMT_S, 5'd2, 64'h0000_0000_B000_0002);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        chk($sformatf("rr%0d.alu_gnt", i), {63'd0, bus.AluGnt}, {63'd0, (i % 2 == 0)});
        chk($sformatf("rr%0d.ld_gnt", i),  {63'd0, bus.LdGnt},  {63'd0, (i % 2 == 1)});
        if (i > 0) begin
          chk($sformatf("rr%0d.we", i),  {63'd0, bus.FPRegWrite}, 64'd1);
          chk($sformatf("rr%0d.reg", i), {59'd0, bus.FPWriteRegister}, {59'd0, last_reg});
        end
        last_reg = (i % 2 == 0) ? bus.AluReg : bus.LdReg;
        @(posedge clk);
        #1;
        if (i % 2 == 0) bus.AluReg = nr;
        else bus.LdReg = nr;
        nr = nr + 5'd1;
      end
    end

    // ALU double with load single waiting: no grant in the low-word cycle.
    do_reset();
    drive(1'b1, FMT_D, 5'd10, 64'hCAFE_0001_BEEF_0002, 1'b0, 5'd0, 5'd0, 64'd0);
    @(negedge clk);
    chk("dl.c0.alu_gnt", {63'd0, bus.AluGnt}, 64'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 5'd0, 64'd0, 1'b1, FMT_S, 5'd20, 64'h0000_0000_7777_0020);
    @(negedge clk);
    chk("dl.c1.ld_gnt", {63'd0, bus.LdGnt}, 64'd0);
    chk_port("dl.c1", 1'b1, 5'd10, 32'hBEEF_0002, 1'b1);
    @(negedge clk);
    chk("dl.c2.ld_gnt", {63'd0, bus.LdGnt}, 64'd1);
    chk_port("dl.c2", 1'b1, 5'd11, 32'hCAFE_0001, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 64'd0);
    @(negedge clk);
    chk_port("dl.c3", 1'b1, 5'd20, 32'h7777_0020, 1'b1);
    @(negedge clk);
    chk_port("dl.c4", 1'b0, 5'd0, 32'd0, 1'b0);

    // Reset during the low word of a double aborts the high word.
    do_reset();
    drive(1'b1, FMT_D, 5'd4, 64'h5555_6666_7777_8888, 1'b0, 5'd0, 5'd0, 64'd0);
    @(negedge clk);
    chk("ab.alu_gnt", {63'd0, bus.AluGnt}, 64'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 64'd0);
    @(negedge clk);
    chk_port("ab.lo", 1'b1, 5'd4, 32'h7777_8888, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_port("ab.rst", 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_port($sformatf("ab.after%0d", i), 1'b0, 5'd0, 32'd0, 1'b0);
    end

    // Random run against a queue-of-pending-words model.
    do_reset();
    a_req = 1'b0; l_req = 1'b0;
    a_fmt = 5'd0; a_reg = 5'd0; a_data = 64'd0;
    l_fmt = 5'd0; l_reg = 5'd0; l_data = 64'd0;
    m_ptr_ld = 1'b0;
    m_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic elig, e_ag, e_lg, e_we, e_b;
      logic [4:0] e_reg;
      logic [31:0] e_d;
      logic [4:0] w_fmt, w_reg;
      logic [63:0] w_data;
      if (!a_req && $urandom_range(0, 2) == 0) begin
        a_req = 1'b1; a_fmt = rand_fmt(); a_reg = 5'($urandom_range(0, 31));
        a_data = {$urandom, $urandom};
      end
      if (!l_req && $urandom_range(0, 2) == 0) begin
        l_req = 1'b1; l_fmt = rand_fmt(); l_reg = 5'($urandom_range(0, 31));
        l_data = {$urandom, $urandom};
      end
      drive(a_req, a_fmt, a_reg, a_data, l_req, l_fmt, l_reg, l_data);
      @(negedge clk);
      // A new request fits once at most the current word remains queued.
      elig = (m_q.size() <= 1);
      e_ag = 1'b0;
      e_lg = 1'b0;
      if (elig && a_req && l_req) begin
        if (m_ptr_ld) e_lg = 1'b1;
        else e_ag = 1'b1;
      end else if (elig && a_req) begin
        e_ag = 1'b1;
      end else if (elig && l_req) begin
        e_lg = 1'b1;
      end
      if (m_q.size() > 0) begin
        e_reg = m_q[0].r; e_d = m_q[0].d; e_we = (m_q[0].r != 5'd0); e_b = 1'b1;
      end else begin
        e_reg = 5'd0; e_d = 32'd0; e_we = 1'b0; e_b = 1'b0;
      end
      chk("rnd.alu_gnt", {63'd0, bus.AluGnt}, {63'd0, e_ag});
      chk("rnd.ld_gnt",  {63'd0, bus.LdGnt},  {63'd0, e_lg});
      chk_port("rnd", e_we, e_reg, e_d, e_b);
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (e_ag || e_lg) begin
        w_fmt  = e_ag ? a_fmt  : l_fmt;
        w_reg  = e_ag ? a_reg  : l_reg;
        w_data = e_ag ? a_data : l_data;
        if (w_fmt == FMT_S) begin
          m_q.push_back('{w_reg, w_data[31:0]});
        end else if (w_fmt == FMT_D) begin
          m_q.push_back('{w_reg, w_data[31:0]});
          m_q.push_back('{5'((w_reg + 1) % 32), w_data[63:32]});
        end
        m_ptr_ld = e_ag;
        if (e_ag) a_req = 1'b0;
        else l_req = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_wb_arbiter.md
FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 Parameter FMT_S, default 5'h10, single-precision format code.
REQ-002 Parameter FMT_D, default 5'h11, double-precision format code.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 AluReq  input  1  FP ALU writeback request; held high with fields stable until AluGnt.
REQ-006 AluFmt  input  5  ALU result format code.
REQ-007 AluReg  input  5  ALU destination FP register.
REQ-008 AluData  input  64  ALU result; [31:0] low word, [63:32] high word.
REQ-009 AluGnt  output  1  one-cycle pulse; ALU request accepted at this edge.
REQ-010 LdReq, LdFmt(5), LdReg(5), LdData(64)  input  FP load writeback request, same rules as ALU.
REQ-011 LdGnt  output  1  one-cycle pulse; load request accepted at this edge.
REQ-012 FPRegWrite  output  1  write strobe to FP register file (one 32-bit word per cycle).
REQ-013 FPWriteRegister  output  5  register written this cycle.
REQ-014 FPWriteData  output  32  word written this cycle.
REQ-015 Busy  output  1  high when state is not IDLE.

Function
REQ-016 Grants and the state register SHALL be decided combinationally from inputs and state, and all write-port outputs SHALL be driven from registered state and the capture register only (no input-to-output combinational path).
REQ-017 States SHALL be IDLE, WR_S (single word), WR_LO (double low word), WR_HI (double high word).
REQ-018 A grant SHALL be issuable only when state is IDLE, WR_S or WR_HI (back-to-back acceptance with zero bubble); never in WR_LO.
REQ-019 At most one of AluGnt/LdGnt SHALL be high in any cycle; each grant is a single-cycle pulse.
REQ-020 Single requester pending: that requester SHALL be granted; both pending: the requester indicated by the round-robin pointer SHALL win.
REQ-021 The pointer SHALL point to the non-granted requester after every grant; unchanged when no grant.
REQ-022 At a grant edge, fmt/reg/data of the winner SHALL be captured; next state is WR_S for FMT_S, WR_LO for FMT_D.
REQ-023 Any other fmt SHALL be granted and dropped: no write, next state IDLE (unless a new grant in same cycle is impossible: next state IDLE).
REQ-024 WR_S: FPRegWrite=1, FPWriteRegister=captured reg, FPWriteData=data[31:0]; one cycle.
REQ-025 WR_LO: writes captured reg with data[31:0]; next state unconditionally WR_HI.
REQ-026 WR_HI: writes (captured reg + 1) mod 32 with data[63:32]; reg 31 wraps to 0.
REQ-027 Any write whose target register is 0 SHALL have FPRegWrite forced to 0 (other outputs unchanged); sequencing is unaffected.
REQ-028 Latency: grant at edge N -> first write in cycle after edge N; double completes one cycle later.
REQ-029 In WR_S/WR_HI with no grant, next state SHALL be IDLE.
REQ-030 In IDLE: FPRegWrite=0, FPWriteRegister=0, FPWriteData=0.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, FPRegWrite=0, AluGnt=LdGnt=0, Busy=0, capture register 0, pointer to ALU.
REQ-032 Reset during WR_LO SHALL abort the double: the high word is never written after reset release.
REQ-033 First cycle after release with both requesting SHALL grant ALU.

Verification
REQ-034 ALU single fmt 10, reg 5, data 0x...DEADBEEF -> AluGnt one cycle, next cycle FPRegWrite=1, reg 5, 0xDEADBEEF; then IDLE.
REQ-035 Load double fmt 11, reg 31, data 0x11112222_33334444 -> writes reg 31 = 0x33334444, next cycle FPRegWrite=0 (reg 0), FPWriteData=0x11112222.
REQ-036 Both request continuously, singles -> grants alternate ALU, Ld, ALU, Ld with FPRegWrite high every cycle, no bubble.
REQ-037 ALU double then Ld single pending -> no grant during WR_LO; LdGnt in WR_HI cycle; Ld write directly follows high word.
REQ-038 rst_n pulsed low during WR_LO of reg 4 double -> reg 4 written, reg 5 never written, Busy=0 on reset.
REQ-039 ALU fmt 5'h14 -> AluGnt pulse, no FPRegWrite, state stays IDLE.
